// File: rtl/fpu_wb_buffer_if.sv
// Handshake bundle between the FPU result stage, the writeback buffer and the
// register file write port. The buffer takes the slave view; the surrounding
// pipeline (or a bench) takes the master view.
interface fpu_wb_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_select;
  logic [4:0]  rd_addr;
  logic        int_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_int_dest;

  modport slave (
    input  in_valid, fpu_result, fpu_select, rd_addr, int_dest, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_int_dest
  );

  modport master (
    output in_valid, fpu_result, fpu_select, rd_addr, int_dest, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_int_dest
  );
endinterface

// File: rtl/fpu_wb_buffer.sv
// Writeback buffer behind the FPU datapath. Each result is tagged with IEEE
// exception flags derived from its encoding, queued in a small FIFO, and
// handed to the register file write port. Flags of committed entries
// accumulate into fflags until software clears them.
module fpu_wb_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [4:0]  ARITH_LO  = 5'd1,
  parameter logic [4:0]  ARITH_HI  = 5'd4,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            fflags_clr,
  output logic [4:0]      fflags,
  fpu_wb_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Flag bit positions within {NV,DZ,OF,UF,NX}
  localparam logic [4:0] FLG_NV    = 5'b10000;
  localparam logic [4:0] FLG_DZ    = 5'b01000;
  localparam logic [4:0] FLG_OF_NX = 5'b00101;
  localparam logic [4:0] FLG_UF_NX = 5'b00011;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] data_mem [DEPTH];
  logic [4:0]  rd_mem   [DEPTH];
  logic        int_mem  [DEPTH];
  logic [4:0]  flg_mem  [DEPTH];

  logic        push;
  logic        pop;
  logic        is_arith;
  logic [7:0]  res_exp;
  logic [22:0] res_mant;
  logic [31:0] in_data;
  logic [4:0]  in_flags;

  // Classify the incoming result and canonicalise NaNs from arithmetic ops
  always_comb begin
    res_exp  = bus.fpu_result[30:23];
    res_mant = bus.fpu_result[22:0];
    is_arith = (bus.fpu_select >= ARITH_LO) && (bus.fpu_select <= ARITH_HI) && !bus.int_dest;
    in_data  = bus.fpu_result;
    in_flags = '0;
    if (is_arith) begin
      if (res_exp == 8'hFF) begin
        if (res_mant != '0) begin
          in_flags = FLG_NV;
          in_data  = CANON_NAN;
        end else if (bus.fpu_select == ARITH_HI) begin
          in_flags = FLG_DZ;
        end else begin
          in_flags = FLG_OF_NX;
        end
      end else if ((res_exp == 8'h00) && (res_mant != '0)) begin
        in_flags = FLG_UF_NX;
      end
    end
  end

  // Handshake qualifiers; in_ready depends only on registered occupancy so a
  // full buffer never passes a new entry through on a same-cycle pop
  always_comb begin
    bus.in_ready  = (count != CW'(DEPTH));
    bus.out_valid = (count != '0);
    push          = bus.in_valid && bus.in_ready && !flush;
    pop           = bus.out_valid && bus.out_ready;
  end

  // Head entry presentation; zeroed when empty so stale storage never leaks
  always_comb begin
    bus.out_data     = '0;
    bus.out_rd       = '0;
    bus.out_int_dest = 1'b0;
    if (bus.out_valid) begin
      bus.out_data     = data_mem[rd_ptr];
      bus.out_rd       = rd_mem[rd_ptr];
      bus.out_int_dest = int_mem[rd_ptr];
    end
  end

  // Entry storage, written on accepted push only
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      data_mem[wr_ptr] <= in_data;
      rd_mem[wr_ptr]   <= bus.rd_addr;
      int_mem[wr_ptr]  <= bus.int_dest;
      flg_mem[wr_ptr]  <= in_flags;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky exception flags; a pop during flush still commits its flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fflags <= '0;
    end else if (pop) begin
      fflags <= fflags_clr ? flg_mem[rd_ptr] : (fflags | flg_mem[rd_ptr]);
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Directed bench for fpu_wb_buffer: stimulus queues expected head entries,
// a negedge monitor compares every committed pop against the queue.
module tb_fpu_wb_buffer;
  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic       fflags_clr;
  logic [4:0] fflags;

  fpu_wb_buffer_if intf();

  fpu_wb_buffer dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .fflags_clr (fflags_clr),
    .fflags     (fflags),
    .bus        (intf.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        id;
  } entry_t;

  entry_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one result for a cycle; expected entry queued only if accepted
  task automatic put(input logic [31:0] d, input logic [4:0] sel, input logic [4:0] rd,
                     input logic id, input logic [31:0] exp_d);
    intf.in_valid   = 1'b1;
    intf.fpu_result = d;
    intf.fpu_select = sel;
    intf.rd_addr    = rd;
    intf.int_dest   = id;
    if (intf.in_ready && !flush) sb.push_back('{data: exp_d, rd: rd, id: id});
    step();
    intf.in_valid = 1'b0;
  endtask

  // Scoreboard monitor: compares the head whenever a pop will take effect
  always @(negedge clk) begin
    if (resetn && intf.out_valid && intf.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected none", intf.out_data);
      end else begin
        entry_t e;
        e = sb.pop_front();
        check("head_entry", {26'd0, intf.out_int_dest, intf.out_rd, intf.out_data},
              {26'd0, e.id, e.rd, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    intf.in_valid = 1'b0; intf.fpu_result = '0; intf.fpu_select = '0;
    intf.rd_addr = '0; intf.int_dest = 1'b0; intf.out_ready = 1'b0;

    // Reset
    step(); step();
    check("rst_out_valid", intf.out_valid, 0);
    check("rst_in_ready", intf.in_ready, 1);
    check("rst_fflags", fflags, 0);
    check("rst_out_data", intf.out_data, 0);
    resetn = 1'b1;
    step();

    // Normal value held under backpressure
    put(32'h40F00000, 5'd1, 5'd3, 1'b0, 32'h40F00000);
    check("t2_valid", intf.out_valid, 1);
    check("t2_data", intf.out_data, 32'h40F00000);
    check("t2_rd", intf.out_rd, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold", {intf.out_valid, intf.out_rd, intf.out_data}, {1'b1, 5'd3, 32'h40F00000});
    end
    intf.out_ready = 1'b1;
    step();
    check("t2_popped", intf.out_valid, 0);
    check("t2_fflags", fflags, 0);

    // NaN canonicalised, NV committed
    put(32'h7F800001, 5'd2, 5'd5, 1'b0, 32'h7FC00000);
    step();
    check("t3_fflags", fflags, 5'b10000);

    // Divide-by-zero then underflow accumulate
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    check("clr_alone", fflags, 0);
    put(32'h7F800000, 5'd4, 5'd7, 1'b0, 32'h7F800000);
    step();
    check("t4_dz", fflags, 5'b01000);
    put(32'h00000001, 5'd3, 5'd8, 1'b0, 32'h00000001);
    step();
    check("t4_dz_uf", fflags, 5'b01011);
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    check("t4_clr", fflags, 0);

    // Overflow from non-divide, clear-with-pop keeps only popped flags
    put(32'h7F800000, 5'd2, 5'd9, 1'b0, 32'h7F800000);
    step();
    check("of_nx", fflags, 5'b00101);
    put(32'h00000001, 5'd1, 5'd10, 1'b0, 32'h00000001);
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    check("clr_with_pop", fflags, 5'b00011);
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;

    // Non-arithmetic selects and integer destinations pass through untouched
    put(32'h7FC12345, 5'd0, 5'd10, 1'b0, 32'h7FC12345);
    step();
    put(32'h7F800001, 5'd2, 5'd11, 1'b1, 32'h7F800001);
    step();
    put(32'h7F800001, 5'd5, 5'd12, 1'b0, 32'h7F800001);
    step();
    check("non_arith_flags", fflags, 0);

    // Fill, back-pressure, pop+push ordering
    intf.out_ready = 1'b0;
    put(32'h3F800000, 5'd1, 5'd1, 1'b0, 32'h3F800000);
    put(32'h40000000, 5'd1, 5'd2, 1'b0, 32'h40000000);
    intf.in_valid = 1'b1; intf.fpu_result = 32'h40400000;
    check("t5_full", intf.in_ready, 0);
    step();
    intf.in_valid = 1'b0;
    check("t5_head", intf.out_data, 32'h3F800000);
    intf.out_ready = 1'b1;
    step();
    intf.out_ready = 1'b0;
    check("t5_head2", intf.out_data, 32'h40000000);
    intf.out_ready = 1'b1;
    put(32'h40800000, 5'd1, 5'd4, 1'b0, 32'h40800000);
    intf.out_ready = 1'b0;
    check("t5_pp_head", {intf.out_valid, intf.out_data}, {1'b1, 32'h40800000});
    put(32'h40A00000, 5'd1, 5'd5, 1'b0, 32'h40A00000);
    check("t5_count2", intf.in_ready, 0);
    intf.out_ready = 1'b1;
    intf.in_valid = 1'b1; intf.fpu_result = 32'h40C00000;
    check("t5_no_passthru", intf.in_ready, 0);
    step();
    intf.in_valid = 1'b0;
    step();
    intf.out_ready = 1'b0;
    check("t5_drained", intf.out_valid, 0);

    // Flush drops queued NaNs without committing flags
    put(32'h7F800001, 5'd1, 5'd1, 1'b0, 32'h7FC00000);
    put(32'h7FFFFFFF, 5'd3, 5'd2, 1'b0, 32'h7FC00000);
    flush = 1'b1; step(); flush = 1'b0;
    sb.delete();
    check("t6_flush_valid", intf.out_valid, 0);
    check("t6_flush_fflags", fflags, 0);
    check("t6_flush_ready", intf.in_ready, 1);
    flush = 1'b1;
    put(32'h3F800000, 5'd1, 5'd6, 1'b0, 32'h3F800000);
    flush = 1'b0;
    check("t6_push_in_flush", intf.out_valid, 0);
    put(32'h7F800001, 5'd1, 5'd7, 1'b0, 32'h7FC00000);
    intf.out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; intf.out_ready = 1'b0;
    sb.delete();
    check("t6_pop_in_flush", {intf.out_valid, fflags}, {1'b0, 5'b10000});

    // Reset in the middle of a handshake
    put(32'h40000000, 5'd1, 5'd4, 1'b1, 32'h40000000);
    check("t6_pre_rst", {intf.out_valid, intf.out_int_dest}, 2'b11);
    intf.out_ready = 1'b1; resetn = 1'b0;
    step();
    check("t6_rst_outs", {intf.out_valid, intf.in_ready, intf.out_int_dest, intf.out_rd, intf.out_data},
          {1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
    check("t6_rst_fflags", fflags, 0);
    resetn = 1'b1; intf.out_ready = 1'b0;
    sb.delete();
    step();
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
